forward_scoreboard: RTL and testbench

- Parametrised operand-bypass and issue-hazard unit for the N-issue in-order integer pipeline. Sits in Decode.
- Resolves every source operand of up to LANES instructions against all in-flight writers in the forwarding stages (E, M, ...).
- Keeps a per-register countdown scoreboard for multi-cycle producers (load, mul/div) and produces a prefix-ordered issue grant.
- This block is the stall source for Decode.

---
 rtl/cdim_fwd_pkg.sv | 15 +
 rtl/forward_scoreboard_if.sv | 37 +++
 rtl/forwarding_mux_n.sv | 28 ++
 rtl/forward_scoreboard.sv | 98 +++++++++
 tb/tb_forward_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdim_fwd_pkg.sv
// Shared types for the Decode operand-bypass and issue-hazard unit.
package cdim_fwd_pkg;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT_W  = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]  lat_t;

  typedef struct packed {
    logic              wen;
    reg_addr_t         waddr;
    logic [DATA_W-1:0] wdata;
  } fw_entry_t;
endpackage

// File: rtl/forward_scoreboard_if.sv
// Decode-side bundle: operand reads, destinations, forwarding entries and grant.
interface forward_scoreboard_if
  import cdim_fwd_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned SRCS   = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned LAT_W  = 3
);
  logic                           flush;
  logic [LANES-1:0]               D_valid;
  logic [LANES*SRCS*REG_AW-1:0]   D_src_addr;
  logic [LANES*SRCS*DW-1:0]       D_src_data;
  logic [LANES*SRCS*DW-1:0]       D_src_value;
  logic [LANES-1:0]               D_dst_wen;
  logic [LANES*REG_AW-1:0]        D_dst_addr;
  logic [LANES*LAT_W-1:0]         D_dst_lat;
  logic                           D_fire;
  logic [STAGES*LANES-1:0]        fw_wen;
  logic [STAGES*LANES*REG_AW-1:0] fw_waddr;
  logic [STAGES*LANES*DW-1:0]     fw_wdata;
  logic [LANES-1:0]               issue_ok;
  logic                           D_stall;

  modport master (
    output flush, D_valid, D_src_addr, D_src_data, D_dst_wen, D_dst_addr,
           D_dst_lat, D_fire, fw_wen, fw_waddr, fw_wdata,
    input  D_src_value, issue_ok, D_stall
  );

  modport slave (
    input  flush, D_valid, D_src_addr, D_src_data, D_dst_wen, D_dst_addr,
           D_dst_lat, D_fire, fw_wen, fw_waddr, fw_wdata,
    output D_src_value, issue_ok, D_stall
  );
endinterface

// File: rtl/forwarding_mux_n.sv
// Priority bypass for one source operand: youngest stage first, higher lane within a stage.
module forwarding_mux_n
  import cdim_fwd_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DW     = 32
) (
  input  reg_addr_t                   addr_i,
  input  logic [DW-1:0]               rf_data_i,
  input  fw_entry_t [STAGES*LANES-1:0] ent_i,
  output logic [DW-1:0]               value_o
);

  // Walk from lowest to highest priority so the last hit is the youngest writer.
  always_comb begin
    value_o = rf_data_i;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (ent_i[s*int'(LANES)+l].wen && (ent_i[s*int'(LANES)+l].waddr == addr_i)) begin
          value_o = DW'(ent_i[s*int'(LANES)+l].wdata);
        end
      end
    end
    if (addr_i == '0) value_o = '0;
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Decode operand bypass plus per-register countdown scoreboard and prefix issue grant.
module forward_scoreboard
  import cdim_fwd_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned SRCS   = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned LAT_W  = 3
) (
  input logic                 clk,
  input logic                 rst,
  forward_scoreboard_if.slave bus
);

  localparam int unsigned NENT = STAGES * LANES;

  fw_entry_t [NENT-1:0] ent;
  reg_addr_t            src_a [LANES][SRCS];
  reg_addr_t            dst_a [LANES];
  logic [LAT_W-1:0]     dst_l [LANES];
  logic [LAT_W-1:0]     cnt_q [NREG];
  logic [LAT_W-1:0]     cnt_d [NREG];
  logic [LANES-1:0]     lane_ok_c;
  logic [LANES-1:0]     issue_ok_c;

  always_comb begin
    for (int e = 0; e < int'(NENT); e++) begin
      ent[e].wen   = bus.fw_wen[e];
      ent[e].waddr = bus.fw_waddr[e*REG_AW +: REG_AW];
      ent[e].wdata = DATA_W'(bus.fw_wdata[e*DW +: DW]);
    end
    for (int j = 0; j < int'(LANES); j++) begin
      for (int s = 0; s < int'(SRCS); s++) begin
        src_a[j][s] = bus.D_src_addr[(j*int'(SRCS)+s)*REG_AW +: REG_AW];
      end
      dst_a[j] = bus.D_dst_addr[j*REG_AW +: REG_AW];
      dst_l[j] = bus.D_dst_lat[j*LAT_W +: LAT_W];
    end
  end

  for (genvar k = 0; k < int'(LANES * SRCS); k++) begin : g_mux
    forwarding_mux_n #(.STAGES(STAGES), .LANES(LANES), .DW(DW)) u_mux (
      .addr_i    (bus.D_src_addr[k*REG_AW +: REG_AW]),
      .rf_data_i (bus.D_src_data[k*DW +: DW]),
      .ent_i     (ent),
      .value_o   (bus.D_src_value[k*DW +: DW])
    );
  end

  // Per-lane hazards: busy sources, RAW on an older lane, and a second multi-cycle writer.
  always_comb begin
    for (int j = 0; j < int'(LANES); j++) begin
      lane_ok_c[j] = bus.D_valid[j];
      for (int s = 0; s < int'(SRCS); s++) begin
        if ((src_a[j][s] != '0) && (cnt_q[src_a[j][s]] != '0)) lane_ok_c[j] = 1'b0;
      end
      for (int i = 0; i < j; i++) begin
        if (bus.D_dst_wen[i] && (dst_a[i] != '0)) begin
          for (int s = 0; s < int'(SRCS); s++) begin
            if (src_a[j][s] == dst_a[i]) lane_ok_c[j] = 1'b0;
          end
          if (bus.D_dst_wen[j] && (dst_a[j] == dst_a[i]) && (dst_l[i] != '0)) lane_ok_c[j] = 1'b0;
        end
      end
    end
    issue_ok_c[0] = lane_ok_c[0];
    for (int j = 1; j < int'(LANES); j++) begin
      issue_ok_c[j] = issue_ok_c[j-1] & lane_ok_c[j];
    end
  end

  assign bus.issue_ok = issue_ok_c;
  assign bus.D_stall  = bus.D_valid[0] & ~issue_ok_c[0];

  // The count holds the stall cycles still owed, so a producer of latency L frees its readers L cycles after firing.
  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
    end
    for (int l = 0; l < int'(LANES); l++) begin
      if (bus.D_fire && issue_ok_c[l] && bus.D_dst_wen[l] && (dst_a[l] != '0) && (dst_l[l] != '0)) begin
        cnt_d[dst_a[l]] = dst_l[l] - LAT_W'(1);
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Randomized and directed bench for forward_scoreboard against a ready-time reference model.
module tb_forward_scoreboard;
  import cdim_fwd_pkg::*;

  localparam int unsigned LANES  = 2;
  localparam int unsigned SRCS   = 2;
  localparam int unsigned STAGES = 2;
  localparam int unsigned DW     = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned LW     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forward_scoreboard_if #(.LANES(LANES), .SRCS(SRCS), .STAGES(STAGES), .DW(DW), .LAT_W(LW)) bus ();

  forward_scoreboard #(.LANES(LANES), .SRCS(SRCS), .STAGES(STAGES), .DW(DW), .NREG(NREG), .LAT_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_at [NREG];

  logic            vld  [LANES];
  logic [4:0]      sa   [LANES][SRCS];
  logic [DW-1:0]   sd   [LANES][SRCS];
  logic            wen  [LANES];
  logic [4:0]      da   [LANES];
  lat_t            lat  [LANES];
  logic            fire, flush;
  logic            fwen [STAGES][LANES];
  logic [4:0]      fwa  [STAGES][LANES];
  logic [DW-1:0]   fwd  [STAGES][LANES];
  logic [LANES-1:0] g_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference bypass: first hit scanning stage 0 upward, higher lane first.
  function automatic logic [DW-1:0] m_fwd(input int l, input int s);
    if (sa[l][s] == 5'd0) return '0;
    for (int st = 0; st < int'(STAGES); st++)
      for (int ln = int'(LANES) - 1; ln >= 0; ln--)
        if (fwen[st][ln] && fwa[st][ln] == sa[l][s]) return fwd[st][ln];
    return sd[l][s];
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && (cyc < ready_at[r]);
  endfunction

  function automatic logic [LANES-1:0] m_grant();
    logic [LANES-1:0] g;
    bit pre = 1'b1;
    for (int j = 0; j < int'(LANES); j++) begin
      bit ok = vld[j];
      for (int s = 0; s < int'(SRCS); s++) if (m_busy(sa[j][s])) ok = 1'b0;
      for (int i = 0; i < j; i++) begin
        if (wen[i] && da[i] != 5'd0) begin
          for (int s = 0; s < int'(SRCS); s++) if (sa[j][s] == da[i]) ok = 1'b0;
          if (wen[j] && da[j] == da[i] && lat[i] != '0) ok = 1'b0;
        end
      end
      pre = pre & ok;
      g[j] = pre;
    end
    return g;
  endfunction

  task automatic clear_in();
    rst = 1'b0; flush = 1'b0; fire = 1'b0;
    for (int l = 0; l < int'(LANES); l++) begin
      vld[l] = 1'b0; wen[l] = 1'b0; da[l] = '0; lat[l] = '0;
      for (int s = 0; s < int'(SRCS); s++) begin sa[l][s] = '0; sd[l][s] = '0; end
    end
    for (int st = 0; st < int'(STAGES); st++)
      for (int l = 0; l < int'(LANES); l++) begin fwen[st][l] = 1'b0; fwa[st][l] = '0; fwd[st][l] = '0; end
  endtask

  task automatic apply();
    bus.flush  = flush;
    bus.D_fire = fire;
    for (int l = 0; l < int'(LANES); l++) begin
      bus.D_valid[l]   = vld[l];
      bus.D_dst_wen[l] = wen[l];
      bus.D_dst_addr[l*REG_AW +: REG_AW] = da[l];
      bus.D_dst_lat[l*LW +: LW] = lat[l];
      for (int s = 0; s < int'(SRCS); s++) begin
        bus.D_src_addr[(l*int'(SRCS)+s)*REG_AW +: REG_AW] = sa[l][s];
        bus.D_src_data[(l*int'(SRCS)+s)*DW +: DW] = sd[l][s];
      end
    end
    for (int st = 0; st < int'(STAGES); st++)
      for (int l = 0; l < int'(LANES); l++) begin
        bus.fw_wen[st*int'(LANES)+l] = fwen[st][l];
        bus.fw_waddr[(st*int'(LANES)+l)*REG_AW +: REG_AW] = fwa[st][l];
        bus.fw_wdata[(st*int'(LANES)+l)*DW +: DW] = fwd[st][l];
      end
    #1;
    g_exp = m_grant();
  endtask

  task automatic check_all();
    check_eq("issue_ok", 32'(bus.issue_ok), 32'(g_exp));
    check_eq("D_stall", 32'(bus.D_stall), 32'(vld[0] & ~g_exp[0]));
    for (int l = 0; l < int'(LANES); l++)
      for (int s = 0; s < int'(SRCS); s++)
        check_eq($sformatf("value_l%0d_s%0d", l, s),
                 bus.D_src_value[(l*int'(SRCS)+s)*DW +: DW], m_fwd(l, s));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      for (int r = 0; r < int'(NREG); r++) ready_at[r] = 0;
    end else if (fire) begin
      for (int l = 0; l < int'(LANES); l++)
        if (g_exp[l] && wen[l] && da[l] != 5'd0 && lat[l] != '0) ready_at[da[l]] = cyc + int'(lat[l]);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    apply();
    check_all();
    tick();
  endtask

  task automatic read_reg(input logic [4:0] r);
    clear_in();
    vld[0] = 1'b1; sa[0][0] = r; fire = 1'b1;
  endtask

  task automatic write_reg(input logic [4:0] r, input lat_t l);
    clear_in();
    vld[0] = 1'b1; wen[0] = 1'b1; da[0] = r; lat[0] = l; fire = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < int'(NREG); r++) ready_at[r] = 0;
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    apply();
    tick();

    // Reset state: counts are clear, a hazard-free full bundle is granted.
    rst = 1'b1; vld[0] = 1'b1; vld[1] = 1'b1;
    apply();
    check_eq("rst_issue_ok", 32'(bus.issue_ok), 32'h3);
    check_eq("rst_stall", 32'(bus.D_stall), 32'h0);
    check_all();
    tick();

    // Forwarding priority.
    clear_in();
    vld[0] = 1'b1; sa[0][0] = 5'd5; sd[0][0] = 32'h1111;
    fwen[0][1] = 1'b1; fwa[0][1] = 5'd5; fwd[0][1] = 32'hAAAA;
    fwen[1][0] = 1'b1; fwa[1][0] = 5'd5; fwd[1][0] = 32'hBBBB;
    fwen[0][0] = 1'b1; fwa[0][0] = 5'd0; fwd[0][0] = 32'h1234;
    sa[0][1] = 5'd0; sd[0][1] = 32'h5555;
    apply();
    check_eq("fwd_stage0", bus.D_src_value[31:0], 32'hAAAA);
    check_eq("fwd_r0", bus.D_src_value[63:32], 32'h0);
    check_all();
    tick();
    fwen[0][1] = 1'b0;
    apply();
    check_eq("fwd_stage1", bus.D_src_value[31:0], 32'hBBBB);
    check_all();
    tick();

    // Load latency 2: reader blocked at t+1, granted at t+2.
    write_reg(5'd8, 3'd2);
    step();
    read_reg(5'd8);
    apply();
    check_eq("load_t1_issue", 32'(bus.issue_ok), 32'h0);
    check_eq("load_t1_stall", 32'(bus.D_stall), 32'h1);
    check_all();
    tick();
    apply();
    check_eq("load_t2_issue", 32'(bus.issue_ok), 32'h1);
    check_all();
    tick();

    // Intra-bundle RAW, then the blocked reader re-presented in lane 0.
    clear_in();
    vld[0] = 1'b1; vld[1] = 1'b1; wen[0] = 1'b1; da[0] = 5'd3; sa[1][0] = 5'd3; fire = 1'b1;
    apply();
    check_eq("raw_issue", 32'(bus.issue_ok), 32'h1);
    check_all();
    tick();
    read_reg(5'd3);
    apply();
    check_eq("raw_realign", 32'(bus.issue_ok), 32'h1);
    check_all();
    tick();

    // Flush clears a pending count and ignores a simultaneous fire.
    write_reg(5'd9, 3'd4);
    step();
    write_reg(5'd9, 3'd6);
    flush = 1'b1;
    step();
    read_reg(5'd9);
    apply();
    check_eq("flush_reader", 32'(bus.issue_ok), 32'h1);
    check_all();
    tick();

    // WAW: a later short-latency writer overrides the long one.
    write_reg(5'd4, 3'd5);
    step();
    read_reg(5'd4);
    apply();
    check_eq("waw_blocked", 32'(bus.issue_ok), 32'h0);
    check_all();
    tick();
    write_reg(5'd4, 3'd1);
    step();
    read_reg(5'd4);
    apply();
    check_eq("waw_reader", 32'(bus.issue_ok), 32'h1);
    check_all();
    tick();

    // Reset mid-countdown.
    write_reg(5'd7, 3'd5);
    step();
    clear_in();
    rst = 1'b1;
    step();
    read_reg(5'd7);
    apply();
    check_eq("rst_reader", 32'(bus.issue_ok), 32'h1);
    check_all();
    tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      clear_in();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 49) == 0);
      fire  = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < int'(LANES); l++) begin
        vld[l] = 1'($urandom_range(0, 3) != 0);
        wen[l] = 1'($urandom_range(0, 1));
        da[l]  = 5'($urandom_range(0, 7));
        lat[l] = 3'($urandom_range(0, 7));
        for (int s = 0; s < int'(SRCS); s++) begin
          sa[l][s] = 5'($urandom_range(0, 7));
          sd[l][s] = $urandom;
        end
      end
      for (int st = 0; st < int'(STAGES); st++)
        for (int l = 0; l < int'(LANES); l++) begin
          fwen[st][l] = 1'($urandom_range(0, 1));
          fwa[st][l]  = 5'($urandom_range(0, 7));
          fwd[st][l]  = $urandom;
        end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
